// File: rtl/versatile_mem_ctrl_arb_if.sv
// Bus bundle between the SDRAM-side arbiter and its egress/ingress FIFOs and command engine.
// master = arbiter, slave = FIFOs plus SDRAM command engine.
interface versatile_mem_ctrl_arb_if #(
  parameter int nr_of_wb_ports = 3
);
  logic [35:0]               fifo_dat_i;
  logic [0:nr_of_wb_ports-1] fifo_empty;
  logic                      fifo_rd;
  logic [0:nr_of_wb_ports-1] fifo_re;
  logic [31:0]               fifo_dat_o;
  logic                      fifo_wr;
  logic [0:nr_of_wb_ports-1] fifo_we;
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [29:0]               cmd_adr;
  logic                      cmd_we;
  logic [4:0]                cmd_len;
  logic [31:0]               wr_dat_o;
  logic [3:0]                wr_sel_o;
  logic                      wr_valid;
  logic                      wr_ready;
  logic [31:0]               rd_dat_i;
  logic                      rd_valid;

  modport master (
    input  fifo_dat_i, fifo_empty, cmd_ready, wr_ready, rd_dat_i, rd_valid,
    output fifo_rd, fifo_re, fifo_dat_o, fifo_wr, fifo_we,
           cmd_valid, cmd_adr, cmd_we, cmd_len, wr_dat_o, wr_sel_o, wr_valid
  );

  modport slave (
    output fifo_dat_i, fifo_empty, cmd_ready, wr_ready, rd_dat_i, rd_valid,
    input  fifo_rd, fifo_re, fifo_dat_o, fifo_wr, fifo_we,
           cmd_valid, cmd_adr, cmd_we, cmd_len, wr_dat_o, wr_sel_o, wr_valid
  );
endinterface

// File: rtl/versatile_mem_ctrl_arb.sv
// SDRAM-side arbiter: pops a port's address word, issues one burst command, then moves write data or
// steers read data back. Define SDRAM_ARB_RR_EN for round-robin arbitration (default: fixed priority).
module versatile_mem_ctrl_arb #(
  parameter int nr_of_wb_ports = 3
) (
  input  logic                      sdram_clk,
  input  logic                      sdram_rst,
  versatile_mem_ctrl_arb_if.master  bus
);
  localparam int N  = nr_of_wb_ports;
  localparam int GW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {IDLE, ADR, CMD, WR, RD} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] gnt_q, gnt_d;
  logic [29:0]   adr_q, adr_d;
  logic          we_q, we_d;
  logic [4:0]    len_q, len_d;
  logic [4:0]    pop_cnt_q, pop_cnt_d;
  logic [4:0]    done_q, done_d;
  logic          pend_q, pend_d;
  logic          wr_valid_q, wr_valid_d;
  logic [31:0]   wr_dat_q, wr_dat_d;
  logic [3:0]    wr_sel_q, wr_sel_d;
  logic          fifo_wr_q;
  logic [0:N-1]  fifo_we_q;
  logic [31:0]   fifo_dat_q;

  logic          any_req;
  logic [GW-1:0] win;
  logic          wr_pop;
  logic          rd_take;
  logic          pop_c;
  logic [0:N-1]  re_c;

  function automatic logic [0:N-1] onehot(input logic [GW-1:0] g);
    logic [0:N-1] r;
    r    = '0;
    r[g] = 1'b1;
    return r;
  endfunction

  function automatic logic [4:0] burst_len(input logic [1:0] bte, input logic [2:0] cti);
    logic [4:0] l;
    if (cti == 3'b000 || cti == 3'b111 || bte == 2'b00) l = 5'd1;
    else begin
      case (bte)
        2'b01:   l = 5'd4;
        2'b10:   l = 5'd8;
        default: l = 5'd16;
      endcase
    end
    return l;
  endfunction

  assign any_req = ~&bus.fifo_empty;

`ifdef SDRAM_ARB_RR_EN
  logic [GW-1:0] rr_q;
  int            idx;

  // Descending scan so the queue nearest the pointer is the last (winning) assignment.
  always_comb begin
    win = '0;
    idx = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = int'(rr_q) + i;
      if (idx >= N) idx = idx - N;
      if (!bus.fifo_empty[idx]) win = GW'(idx);
    end
  end

  always_ff @(posedge sdram_clk) begin
    if (!sdram_rst) rr_q <= '0;
    else if (state_q == IDLE && any_req) rr_q <= (int'(win) == N - 1) ? '0 : win + 1'b1;
  end
`else
  always_comb begin
    win = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!bus.fifo_empty[i]) win = GW'(i);
    end
  end
`endif

  // A write pop is allowed only when no word is already in flight and the output slot frees up.
  assign wr_pop  = (state_q == WR) && !bus.fifo_empty[gnt_q] && !pend_q &&
                   (!wr_valid_q || bus.wr_ready) && (pop_cnt_q < len_q);
  assign rd_take = (state_q == RD) && bus.rd_valid;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    adr_d      = adr_q;
    we_d       = we_q;
    len_d      = len_q;
    pop_cnt_d  = pop_cnt_q;
    done_d     = done_q;
    pend_d     = 1'b0;
    wr_valid_d = wr_valid_q;
    wr_dat_d   = wr_dat_q;
    wr_sel_d   = wr_sel_q;
    pop_c      = 1'b0;
    re_c       = '0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d   = win;
          pop_c   = 1'b1;
          re_c    = onehot(win);
          state_d = ADR;
        end
      end
      ADR: begin
        adr_d   = bus.fifo_dat_i[35:6];
        we_d    = bus.fifo_dat_i[5];
        len_d   = burst_len(bus.fifo_dat_i[4:3], bus.fifo_dat_i[2:0]);
        state_d = CMD;
      end
      CMD: begin
        if (bus.cmd_ready) begin
          state_d   = we_q ? WR : RD;
          pop_cnt_d = '0;
          done_d    = '0;
        end
      end
      WR: begin
        if (wr_pop) begin
          pop_c     = 1'b1;
          re_c      = onehot(gnt_q);
          pend_d    = 1'b1;
          pop_cnt_d = pop_cnt_q + 5'd1;
        end
        if (wr_valid_q && bus.wr_ready) begin
          wr_valid_d = 1'b0;
          done_d     = done_q + 5'd1;
          if (done_q + 5'd1 == len_q) state_d = IDLE;
        end
      end
      RD: begin
        if (bus.rd_valid) begin
          done_d = done_q + 5'd1;
          if (done_q + 5'd1 == len_q) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (pend_q) begin
      wr_valid_d = 1'b1;
      wr_dat_d   = bus.fifo_dat_i[35:4];
      wr_sel_d   = bus.fifo_dat_i[3:0];
    end
  end

  always_ff @(posedge sdram_clk) begin
    if (!sdram_rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      adr_q      <= '0;
      we_q       <= 1'b0;
      len_q      <= '0;
      pop_cnt_q  <= '0;
      done_q     <= '0;
      pend_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_dat_q   <= '0;
      wr_sel_q   <= '0;
      fifo_wr_q  <= 1'b0;
      fifo_we_q  <= '0;
      fifo_dat_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      adr_q      <= adr_d;
      we_q       <= we_d;
      len_q      <= len_d;
      pop_cnt_q  <= pop_cnt_d;
      done_q     <= done_d;
      pend_q     <= pend_d;
      wr_valid_q <= wr_valid_d;
      wr_dat_q   <= wr_dat_d;
      wr_sel_q   <= wr_sel_d;
      fifo_wr_q  <= rd_take;
      fifo_we_q  <= rd_take ? onehot(gnt_q) : '0;
      if (rd_take) fifo_dat_q <= bus.rd_dat_i;
    end
  end

  // Pops are combinational, so gate them with reset to keep the queues untouched while held in reset.
  assign bus.fifo_rd    = pop_c & sdram_rst;
  assign bus.fifo_re    = sdram_rst ? re_c : '0;
  assign bus.fifo_wr    = fifo_wr_q;
  assign bus.fifo_we    = fifo_we_q;
  assign bus.fifo_dat_o = fifo_dat_q;
  assign bus.cmd_valid  = (state_q == CMD);
  assign bus.cmd_adr    = adr_q;
  assign bus.cmd_we     = we_q;
  assign bus.cmd_len    = len_q;
  assign bus.wr_valid   = wr_valid_q;
  assign bus.wr_dat_o   = wr_dat_q;
  assign bus.wr_sel_o   = wr_sel_q;
endmodule

// File: tb/tb_versatile_mem_ctrl_arb.sv
// Bench for versatile_mem_ctrl_arb: egress FIFO model, transaction-level scoreboard, directed scenarios.
module tb_versatile_mem_ctrl_arb;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  versatile_mem_ctrl_arb_if #(.nr_of_wb_ports(N)) bus ();
  versatile_mem_ctrl_arb #(.nr_of_wb_ports(N)) dut (
    .sdram_clk (clk),
    .sdram_rst (rst),
    .bus       (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Egress FIFO: registered read data, one cycle after the pop strobe.
  logic [35:0] env_q   [0:N-1][$];
  logic [35:0] model_q [0:N-1][$];

  always @(posedge clk) begin
    if (bus.fifo_rd) begin
      for (int p = 0; p < N; p++)
        if (bus.fifo_re[p] && env_q[p].size() > 0) bus.fifo_dat_i <= env_q[p].pop_front();
    end
    for (int p = 0; p < N; p++) bus.fifo_empty[p] <= (env_q[p].size() == 0);
  end

  function automatic logic [0:N-1] oh(input int g);
    logic [0:N-1] r;
    r = '0;
    if (g >= 0 && g < N) r[g] = 1'b1;
    return r;
  endfunction

  function automatic int model_len(input logic [35:0] w);
    if (w[2:0] == 3'b000 || w[2:0] == 3'b111 || w[4:3] == 2'b00) return 1;
    if (w[4:3] == 2'b01) return 4;
    if (w[4:3] == 2'b10) return 8;
    return 16;
  endfunction

  // First non-empty queue found when walking upward from ptr, wrapping around.
  function automatic int pick(input logic [0:N-1] emp, input int ptr);
    for (int d = 0; d < N; d++)
      if (!emp[(ptr + d) % N]) return (ptr + d) % N;
    return -1;
  endfunction

  // Scoreboard state
  int          mphase = 0;   // 0 await grant, 1 command pending, 2 write burst, 3 read burst
  int          mg = 0, mrr = 0, mlen = 0, mpops = 0, mleft = 0;
  logic [29:0] madr;
  logic        mwe;
  logic [31:0] exp_wd[$];
  logic [3:0]  exp_ws[$];
  logic [31:0] exp_rd[$];
  int          exp_rp[$];
  int          grant_log[$];
  int          pop_cnt = 0, wr_hs = 0;
  logic [29:0] last_adr;
  logic        last_we;
  logic [4:0]  last_len;
  logic [31:0] last_wd;
  logic [3:0]  last_ws;
  logic [31:0] push_d[$];
  logic [0:N-1] push_we[$];
  logic        prev_wait = 1'b0;
  logic [29:0] prev_adr;

  always @(negedge clk) begin
    int          g;
    int          ptr;
    logic [35:0] w;
    if (!rst) begin
      mphase = 0; mrr = 0; prev_wait = 1'b0;
      exp_wd.delete(); exp_ws.delete(); exp_rd.delete(); exp_rp.delete();
    end else begin
      if (bus.fifo_wr) begin
        if (exp_rd.size() == 0) chk("push_unexpected", 1, 0);
        else begin
          chk("push_dat", bus.fifo_dat_o, exp_rd.pop_front());
          chk("push_we", bus.fifo_we, oh(exp_rp.pop_front()));
          push_d.push_back(bus.fifo_dat_o);
          push_we.push_back(bus.fifo_we);
        end
      end
      if (bus.fifo_rd) begin
        pop_cnt++;
        chk("pop_nonempty", |(bus.fifo_re & ~bus.fifo_empty), 1);
        if (mphase == 0) begin
`ifdef SDRAM_ARB_RR_EN
          ptr = mrr;
`else
          ptr = 0;
`endif
          g = pick(bus.fifo_empty, ptr);
          chk("grant", bus.fifo_re, oh(g));
          if (g >= 0 && model_q[g].size() > 0) begin
            w = model_q[g].pop_front();
            madr = w[35:6]; mwe = w[5]; mlen = model_len(w);
            mg = g; mrr = (g + 1) % N;
            grant_log.push_back(g);
            mphase = 1;
          end
        end else if (mphase == 2) begin
          chk("wr_pop_sel", bus.fifo_re, oh(mg));
          chk("wr_pop_in_len", mpops < mlen, 1);
          mpops++;
          if (model_q[mg].size() > 0) begin
            w = model_q[mg].pop_front();
            exp_wd.push_back(w[35:4]);
            exp_ws.push_back(w[3:0]);
          end
        end else chk("pop_phase", mphase, 0);
      end
      if (prev_wait) begin
        chk("cmd_hold_valid", bus.cmd_valid, 1);
        chk("cmd_hold_adr", bus.cmd_adr, prev_adr);
      end
      prev_wait = bus.cmd_valid && !bus.cmd_ready;
      prev_adr  = bus.cmd_adr;
      if (bus.cmd_valid && bus.cmd_ready) begin
        if (mphase != 1) chk("cmd_phase", mphase, 1);
        else begin
          chk("cmd_adr", bus.cmd_adr, madr);
          chk("cmd_we", bus.cmd_we, mwe);
          chk("cmd_len", bus.cmd_len, mlen);
          last_adr = bus.cmd_adr; last_we = bus.cmd_we; last_len = bus.cmd_len;
          mphase = mwe ? 2 : 3;
          mleft = mlen; mpops = 0;
        end
      end
      if (bus.wr_valid && bus.wr_ready) begin
        if (mphase != 2 || exp_wd.size() == 0) chk("wr_unexpected", mphase, 2);
        else begin
          chk("wr_dat", bus.wr_dat_o, exp_wd.pop_front());
          chk("wr_sel", bus.wr_sel_o, exp_ws.pop_front());
          last_wd = bus.wr_dat_o; last_ws = bus.wr_sel_o;
          wr_hs++; mleft--;
          if (mleft == 0) mphase = 0;
        end
      end
      if (bus.rd_valid && mphase == 3) begin
        exp_rd.push_back(bus.rd_dat_i);
        exp_rp.push_back(mg);
        mleft--;
        if (mleft == 0) mphase = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int p, input logic [35:0] w);
    env_q[p].push_back(w);
    model_q[p].push_back(w);
  endtask

  function automatic logic [35:0] aw(input logic [29:0] a, input logic we,
                                     input logic [1:0] bte, input logic [2:0] cti);
    return {a, we, bte, cti};
  endfunction

  task automatic wait_cmd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.cmd_valid && bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk("cmd_timeout", 0, 1);
  endtask

  task automatic serve_read(input int n, input logic [31:0] base);
    bit ok;
    wait_cmd(ok);
    if (ok) begin
      tick();
      for (int i = 0; i < n; i++) begin
        bus.rd_valid = 1'b1;
        bus.rd_dat_i = base + 32'(i);
        tick();
      end
      bus.rd_valid = 1'b0;
    end
  endtask

  task automatic wait_wr(input int target);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (wr_hs >= target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk("wr_timeout", wr_hs, target);
  endtask

  initial begin
    int exp_g[5];
    int p0, w0;
    rst           = 1'b0;
    bus.cmd_ready = 1'b1;
    bus.wr_ready  = 1'b1;
    bus.rd_valid  = 1'b0;
    bus.rd_dat_i  = '0;

    // Reset held with every queue non-empty
    load(0, aw(30'h100, 1'b0, 2'b00, 3'b000));
    load(0, aw(30'h101, 1'b0, 2'b00, 3'b000));
    load(0, aw(30'h102, 1'b0, 2'b00, 3'b000));
    load(1, aw(30'h200, 1'b0, 2'b00, 3'b000));
    load(2, aw(30'h300, 1'b0, 2'b00, 3'b000));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_fifo_rd", bus.fifo_rd, 0);
      chk("rst_cmd_valid", bus.cmd_valid, 0);
      chk("rst_fifo_wr", bus.fifo_wr, 0);
    end
    rst = 1'b1;

    // Arbitration order over five single-word reads
    grant_log.delete();
    push_d.delete();
    for (int k = 0; k < 5; k++) serve_read(1, 32'h5000 + 32'(k * 16));
    tick(); tick();
`ifdef SDRAM_ARB_RR_EN
    exp_g = '{0, 1, 2, 0, 0};
`else
    exp_g = '{0, 0, 0, 1, 2};
`endif
    chk("t5_grant_cnt", grant_log.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < grant_log.size()) chk("t5_grant_order", grant_log[k], exp_g[k]);
    chk("t5_push_cnt", push_d.size(), 5);
    if (push_d.size() == 5) chk("t5_push_last", push_d[4], 32'h5040);

    // Single-word write from port 1
    grant_log.delete();
    p0 = pop_cnt;
    w0 = wr_hs;
    load(1, aw(30'h1234, 1'b1, 2'b00, 3'b000));
    load(1, {32'hDEADBEEF, 4'hF});
    wait_wr(w0 + 1);
    tick(); tick(); tick();
    chk("t2_adr", last_adr, 30'h1234);
    chk("t2_we", last_we, 1);
    chk("t2_len", last_len, 1);
    chk("t2_wdat", last_wd, 32'hDEADBEEF);
    chk("t2_wsel", last_ws, 4'hF);
    chk("t2_pops", pop_cnt - p0, 2);
    chk("t2_grant_cnt", grant_log.size(), 1);
    if (grant_log.size() > 0) chk("t2_grant", grant_log[0], 1);
    chk("t2_idle", bus.cmd_valid | bus.wr_valid | bus.fifo_rd, 0);

    // Port 0 incrementing-4 read
    push_d.delete();
    push_we.delete();
    load(0, aw(30'hABC, 1'b0, 2'b01, 3'b010));
    serve_read(4, 32'hA0);
    tick(); tick();
    chk("t3_len", last_len, 4);
    chk("t3_push_cnt", push_d.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < push_d.size()) begin
        chk("t3_push_dat", push_d[i], 32'hA0 + 32'(i));
        chk("t3_push_we", push_we[i], 3'b100);
      end
    end

    // Wrap-8 write from port 2 with the queue running dry after three words
    w0 = wr_hs;
    load(2, aw(30'h2000, 1'b1, 2'b10, 3'b010));
    for (int i = 0; i < 3; i++) load(2, {32'hC000_0000 + 32'(i), 4'(i + 1)});
    wait_wr(w0 + 3);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_stall_wr_valid", bus.wr_valid, 0);
      chk("t4_stall_no_pop", bus.fifo_rd, 0);
    end
    for (int i = 3; i < 8; i++) load(2, {32'hC000_0000 + 32'(i), 4'(i + 1)});
    wait_wr(w0 + 8);
    tick(); tick();
    chk("t4_len", last_len, 8);
    chk("t4_words", wr_hs - w0, 8);
    chk("t4_last_dat", last_wd, 32'hC000_0007);
    chk("t4_last_sel", last_ws, 4'h8);

    // Command held while the engine stalls
    bus.cmd_ready = 1'b0;
    load(0, aw(30'h3FF0, 1'b0, 2'b00, 3'b000));
    for (int i = 0; i < 50; i++) begin
      if (bus.cmd_valid) break;
      tick();
    end
    chk("t6_cmd_seen", bus.cmd_valid, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t6_hold_valid", bus.cmd_valid, 1);
      chk("t6_hold_adr", bus.cmd_adr, 30'h3FF0);
    end
    bus.cmd_ready = 1'b1;
    serve_read(1, 32'h77);
    tick(); tick();
    chk("t6_read_after_stall", push_d[push_d.size() - 1], 32'h77);

    // Reset in the middle of a write burst
    bus.wr_ready = 1'b0;
    load(1, aw(30'h40, 1'b1, 2'b01, 3'b010));
    load(1, {32'h1111_2222, 4'h3});
    for (int i = 0; i < 50; i++) begin
      if (bus.wr_valid) break;
      tick();
    end
    chk("t6_wr_valid_seen", bus.wr_valid, 1);
    p0 = pop_cnt;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_rst_fifo_rd", bus.fifo_rd, 0);
      chk("t6_rst_wr_valid", bus.wr_valid, 0);
      chk("t6_rst_cmd_valid", bus.cmd_valid, 0);
    end
    rst = 1'b1;
    bus.wr_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("t6_no_pops_after_rst", pop_cnt - p0, 0);
    chk("t6_wr_valid_after_rst", bus.wr_valid, 0);

    // Recovery
    load(2, aw(30'h55, 1'b0, 2'b00, 3'b111));
    serve_read(1, 32'h99);
    tick(); tick();
    chk("recover_adr", last_adr, 30'h55);
    chk("recover_len", last_len, 1);
    chk("recover_push", push_d[push_d.size() - 1], 32'h99);
    chk("end_model_idle", mphase, 0);
    chk("end_exp_empty", exp_wd.size() + exp_rd.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end
endmodule
